// File: rtl/cplx_sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : cplx_sync_fifo_if
// Description : Handshake/status bundle for the complex-sample sync FIFO.
//               master = producer/consumer side, slave = FIFO side.
// Revision    : 1.0 - initial release
// ============================================================================
interface cplx_sync_fifo_if #(
  parameter int FLOAT_LEN = 32,
  parameter int ADDR_LEN  = 3
);
  logic [2*FLOAT_LEN-1:0] din;
  logic                   wr_en;
  logic                   rd_en;
  logic [2*FLOAT_LEN-1:0] dout;
  logic                   dout_valid;
  logic                   full;
  logic                   empty;
  logic                   almost_full;
  logic                   almost_empty;
  logic [ADDR_LEN:0]      count;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output din, wr_en, rd_en,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/cplx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cplx_sync_fifo
// Description : Parametrised synchronous FIFO for packed {re, im} complex
//               samples with level, almost-full/empty and error flags.
//               Define CPLX_FIFO_FWFT_EN for first-word fall-through reads;
//               otherwise reads are registered with one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module cplx_sync_fifo #(
  parameter int FLOAT_LEN = 32,
  parameter int ADDR_LEN  = 3,
  parameter int AF_LEVEL  = 6,
  parameter int AE_LEVEL  = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  cplx_sync_fifo_if.slave   bus
);

  localparam int                c_WIDTH    = 2 * FLOAT_LEN;
  localparam int                c_DEPTH    = 1 << ADDR_LEN;
  localparam logic [ADDR_LEN:0] c_FULL_CNT = {1'b1, {ADDR_LEN{1'b0}}};
  localparam logic [ADDR_LEN:0] c_AF_CNT   = (ADDR_LEN+1)'(AF_LEVEL);
  localparam logic [ADDR_LEN:0] c_AE_CNT   = (ADDR_LEN+1)'(AE_LEVEL);

  logic [c_WIDTH-1:0]  r_mem [c_DEPTH];
  logic [ADDR_LEN-1:0] r_wr_ptr;
  logic [ADDR_LEN-1:0] r_rd_ptr;
  logic [ADDR_LEN:0]   r_count;
  logic                r_overflow;
  logic                r_underflow;

  logic w_full;
  logic w_empty;
  logic w_rd_acc;
  logic w_wr_acc;

  // Status flags are decoded from the registered occupancy only.
  assign w_full   = (r_count == c_FULL_CNT);
  assign w_empty  = (r_count == '0);
  // A write into a full FIFO is only legal when a read frees a slot the same cycle.
  assign w_rd_acc = bus.rd_en & ~w_empty;
  assign w_wr_acc = bus.wr_en & (~w_full | w_rd_acc);

  // Storage write port; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.din;
    end
  end

  // Pointers, occupancy and one-cycle error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_LEN'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + ADDR_LEN'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (ADDR_LEN+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_LEN+1)'(1);
        default: r_count <= r_count;
      endcase
      r_overflow  <= bus.wr_en & ~w_wr_acc;
      r_underflow <= bus.rd_en & ~w_rd_acc;
    end
  end

`ifdef CPLX_FIFO_FWFT_EN
  // Head of queue is always presented; rd_en acknowledges and pops it.
  assign bus.dout       = r_mem[r_rd_ptr];
  assign bus.dout_valid = ~w_empty;
`else
  logic [c_WIDTH-1:0] r_dout;
  logic               r_dout_valid;

  // Registered read port: sample appears one clock after an accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      if (w_rd_acc) begin
        r_dout <= r_mem[r_rd_ptr];
      end
      r_dout_valid <= w_rd_acc;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
`endif

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= c_AF_CNT);
  assign bus.almost_empty = (r_count <= c_AE_CNT);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_cplx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_cplx_sync_fifo
// Description : Directed self-checking bench for cplx_sync_fifo (DEPTH=8).
//               Covers both builds, with and without CPLX_FIFO_FWFT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cplx_sync_fifo;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  cplx_sync_fifo_if #(.FLOAT_LEN(32), .ADDR_LEN(3)) bus ();

  cplx_sync_fifo #(
    .FLOAT_LEN (32),
    .ADDR_LEN  (3),
    .AF_LEVEL  (6),
    .AE_LEVEL  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Sample n packs re=2n+1, im=2n+2 (n=0 -> 0x00000001_00000002).
  function automatic logic [63:0] samp(input int n);
    return {32'(2*n+1), 32'(2*n+2)};
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.din = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    #2;
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    n_tests++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_empty_full got=%b%b exp=10", bus.empty, bus.full); end
    n_tests++; if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost got=%b%b exp=10", bus.almost_empty, bus.almost_full); end
    n_tests++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL reset_errflags got=%b%b exp=00", bus.overflow, bus.underflow); end
    n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.dout_valid); end
`ifndef CPLX_FIFO_FWFT_EN
    n_tests++; if (bus.dout !== 64'd0) begin n_fail++; $display("FAIL reset_dout got=%h exp=0", bus.dout); end
`endif
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int k = 0; k < 8; k++) begin
      bus.din = samp(k); bus.wr_en = 1'b1;
      cyc();
      n_tests++; if (bus.count !== 4'(k+1)) begin n_fail++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", k, bus.count, k+1); end
      n_tests++; if (bus.almost_full !== (k+1 >= 6)) begin n_fail++; $display("FAIL fill_af[%0d] got=%b exp=%b", k, bus.almost_full, (k+1 >= 6)); end
      n_tests++; if (bus.full !== (k == 7)) begin n_fail++; $display("FAIL fill_full[%0d] got=%b exp=%b", k, bus.full, (k == 7)); end
    end
    bus.din = samp(8);
    cyc();
    n_tests++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_pulse got=%b exp=1", bus.overflow); end
    n_tests++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL overflow_count got=%0d exp=8", bus.count); end
    bus.wr_en = 1'b0;
    cyc();
    n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clear got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 8; k++) begin
      bus.rd_en = 1'b1;
      cyc();
      n_tests++; if (bus.dout !== samp(k)) begin n_fail++; $display("FAIL drain_dout[%0d] got=%h exp=%h", k, bus.dout, samp(k)); end
      n_tests++; if (bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d] got=%b exp=1", k, bus.dout_valid); end
      n_tests++; if (bus.count !== 4'(7-k)) begin n_fail++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", k, bus.count, 7-k); end
      n_tests++; if (bus.almost_empty !== (7-k <= 1)) begin n_fail++; $display("FAIL drain_ae[%0d] got=%b exp=%b", k, bus.almost_empty, (7-k <= 1)); end
    end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
    cyc();
    n_tests++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_pulse got=%b exp=1", bus.underflow); end
    n_tests++; if (bus.dout !== samp(7)) begin n_fail++; $display("FAIL underflow_dout_hold got=%h exp=%h", bus.dout, samp(7)); end
    n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL underflow_valid got=%b exp=0", bus.dout_valid); end
    bus.rd_en = 1'b0;
    cyc();
    n_tests++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_clear got=%b exp=0", bus.underflow); end
  endtask

  task automatic test_full_rw();
    for (int k = 0; k < 8; k++) begin
      bus.din = samp(100+k); bus.wr_en = 1'b1;
      cyc();
    end
    bus.rd_en = 1'b1;
    for (int j = 0; j < 20; j++) begin
      bus.din = samp(108+j);
      cyc();
      n_tests++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL fullrw_count[%0d] got=%0d exp=8", j, bus.count); end
      n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fullrw_overflow[%0d] got=%b exp=0", j, bus.overflow); end
      n_tests++; if (bus.dout !== samp(100+j) || bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL fullrw_dout[%0d] got=%h/%b exp=%h/1", j, bus.dout, bus.dout_valid, samp(100+j)); end
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic test_empty_rw();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus.din = 64'hA5; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
    cyc();
    n_tests++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL emptyrw_underflow got=%b exp=1", bus.underflow); end
    n_tests++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL emptyrw_count got=%0d exp=1", bus.count); end
    n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL emptyrw_nobypass got=%b exp=0", bus.dout_valid); end
    bus.wr_en = 1'b0;
    cyc();
    n_tests++; if (bus.dout !== 64'hA5 || bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL emptyrw_dout got=%h/%b exp=a5/1", bus.dout, bus.dout_valid); end
    n_tests++; if (bus.count !== 4'd0 || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL emptyrw_after got=%0d/%b exp=0/0", bus.count, bus.underflow); end
    bus.rd_en = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) begin
      bus.din = samp(200+k); bus.wr_en = 1'b1;
      cyc();
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b1;
    cyc();
    bus.rd_en = 1'b0;
`ifdef CPLX_FIFO_FWFT_EN
    n_tests++; if (bus.dout !== samp(201)) begin n_fail++; $display("FAIL rstmid_pre_dout got=%h exp=%h", bus.dout, samp(201)); end
`else
    n_tests++; if (bus.dout !== samp(200)) begin n_fail++; $display("FAIL rstmid_pre_dout got=%h exp=%h", bus.dout, samp(200)); end
`endif
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_count got=%0d/%b exp=0/1", bus.count, bus.empty); end
    n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", bus.dout_valid); end
`ifndef CPLX_FIFO_FWFT_EN
    n_tests++; if (bus.dout !== 64'd0) begin n_fail++; $display("FAIL rstmid_dout got=%h exp=0", bus.dout); end
`endif
    #1;
    rst = 1'b0;
    bus.rd_en = 1'b1;
    cyc();
    n_tests++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL rstmid_underflow got=%b exp=1", bus.underflow); end
    bus.rd_en = 1'b0;
    cyc();
  endtask

  task automatic test_fwft();
    bus.din = 64'h11; bus.wr_en = 1'b1;
    cyc();
    bus.wr_en = 1'b0;
    n_tests++; if (bus.dout !== 64'h11 || bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL fwft_head got=%h/%b exp=11/1", bus.dout, bus.dout_valid); end
    bus.rd_en = 1'b1;
    cyc();
    bus.rd_en = 1'b0;
    n_tests++; if (bus.dout_valid !== 1'b0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL fwft_pop got=%b/%b exp=0/1", bus.dout_valid, bus.empty); end
    for (int k = 0; k < 3; k++) begin
      bus.din = samp(300+k); bus.wr_en = 1'b1;
      cyc();
    end
    bus.wr_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (bus.dout !== samp(300+k) || bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL fwft_order[%0d] got=%h/%b exp=%h/1", k, bus.dout, bus.dout_valid, samp(300+k)); end
      bus.rd_en = 1'b1;
      cyc();
    end
    bus.rd_en = 1'b0;
    n_tests++; if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin n_fail++; $display("FAIL fwft_drained got=%b/%0d exp=1/0", bus.empty, bus.count); end
  endtask

  // Scenario sequence.
  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_fill();
`ifdef CPLX_FIFO_FWFT_EN
    test_reset();
    test_fwft();
`else
    test_drain();
    test_full_rw();
    test_empty_rw();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
